// File: rtl/int_ctrl_if.sv
// Register-window and control-unit handshake bundle for int_ctrl.
// master = bus/control-unit side, slave = the interrupt controller.
interface int_ctrl_if #(
    parameter int NUM_SRC    = 8,
    parameter int DATA_WIDTH = 32
);
    localparam int ID_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [1:0]            addr;
    logic                  wr;
    logic                  rd;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  hwint;
    logic [ID_W-1:0]       int_id;
    logic                  int_ack;
    logic                  eoi;

    modport master (
        output addr, wr, rd, wdata, int_ack, eoi,
        input  rdata, hwint, int_id
    );

    modport slave (
        input  addr, wr, rd, wdata, int_ack, eoi,
        output rdata, hwint, int_id
    );
endinterface

// File: rtl/int_ctrl.sv
// Interrupt controller: NUM_SRC maskable edge/level sources, fixed priority
// (bit 0 highest), single hwint request with ack/EOI handshake.
module int_ctrl #(
    parameter int NUM_SRC    = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] src,
    int_ctrl_if.slave          bus
);
    localparam int ID_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    localparam logic [1:0] A_ENABLE   = 2'd0;
    localparam logic [1:0] A_PENDING  = 2'd1;
    localparam logic [1:0] A_EDGE_SEL = 2'd2;
    localparam logic [1:0] A_ACTIVE   = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [NUM_SRC-1:0]    s1_q, s2_q, s3_q, s3_d;
    logic [NUM_SRC-1:0]    enable_q, enable_d;
    logic [NUM_SRC-1:0]    pending_q, pending_d;
    logic [NUM_SRC-1:0]    edge_sel_q, edge_sel_d;
    logic [ID_W-1:0]       int_id_q, int_id_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic [NUM_SRC-1:0]    eligible, edge_det, ack_clr, w1c_clr, wdata_src;
    logic [ID_W-1:0]       winner;
    logic                  ack_take;

    assign wdata_src = bus.wdata[NUM_SRC-1:0];

    // NOTE: every variable assigned in an always_comb gets a default at the
    // top of the block, so no path leaves it unassigned and no latch appears.
    always_comb begin
        eligible = pending_q & enable_q;
        winner   = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) winner = ID_W'(i);
        end
    end

    always_comb begin
        state_d  = state_q;
        int_id_d = int_id_q;
        ack_take = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (|eligible) begin
                    state_d  = REQ;
                    int_id_d = winner;
                end
            end
            REQ: begin
                // An ack beats a same-cycle loss of eligibility.
                if (bus.int_ack) begin
                    state_d  = SERVICE;
                    ack_take = 1'b1;
                end else if (eligible == '0) begin
                    state_d = IDLE;
                end else begin
                    int_id_d = winner;
                end
            end
            SERVICE: begin
                if (bus.eoi) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        edge_det = s2_q & ~s3_q;
        ack_clr  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (ack_take && (int_id_q == ID_W'(i))) ack_clr[i] = 1'b1;
        end
        w1c_clr = (bus.wr && bus.addr == A_PENDING) ? wdata_src : '0;

        // Edge bits: a new edge outranks any clear. Level bits follow s2.
        pending_d = ((edge_det | (pending_q & ~(ack_clr | w1c_clr))) & edge_sel_q)
                  | (s2_q & ~edge_sel_q);

        enable_d   = enable_q;
        edge_sel_d = edge_sel_q;
        if (bus.wr && bus.addr == A_ENABLE)   enable_d   = wdata_src;
        if (bus.wr && bus.addr == A_EDGE_SEL) edge_sel_d = wdata_src;

        // On a mode change, align history with the value s2 is about to take
        // so the switch itself never looks like a rising edge.
        s3_d = s2_q;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (edge_sel_d[i] != edge_sel_q[i]) s3_d[i] = s1_q[i];
        end
    end

    // Reads see pre-write register contents.
    always_comb begin
        rdata_d = '0;
        if (bus.rd) begin
            unique case (bus.addr)
                A_ENABLE:   rdata_d[NUM_SRC-1:0] = enable_q;
                A_PENDING:  rdata_d[NUM_SRC-1:0] = pending_q;
                A_EDGE_SEL: rdata_d[NUM_SRC-1:0] = edge_sel_q;
                A_ACTIVE: begin
                    rdata_d[DATA_WIDTH-1] = (state_q == SERVICE);
                    rdata_d[ID_W-1:0]     = int_id_q;
                end
                default: rdata_d = '0;
            endcase
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            s1_q       <= '0;
            s2_q       <= '0;
            s3_q       <= '0;
            enable_q   <= '0;
            pending_q  <= '0;
            edge_sel_q <= '0;
            int_id_q   <= '0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            s1_q       <= src;
            s2_q       <= s1_q;
            s3_q       <= s3_d;
            enable_q   <= enable_d;
            pending_q  <= pending_d;
            edge_sel_q <= edge_sel_d;
            int_id_q   <= int_id_d;
            rdata_q    <= rdata_d;
        end
    end

    assign bus.hwint  = (state_q == REQ);
    assign bus.int_id = int_id_q;
    assign bus.rdata  = rdata_q;

endmodule

// File: tb/tb_int_ctrl.sv
// Randomised bench for int_ctrl: directed handshake scenarios followed by
// random traffic, all outputs compared each cycle against a behavioural model.
module tb_int_ctrl;
    localparam int NS = 8;
    localparam int DW = 32;

    localparam int ST_IDLE = 0;
    localparam int ST_REQ  = 1;
    localparam int ST_SVC  = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [NS-1:0] src = '0;

    int_ctrl_if #(.NUM_SRC(NS), .DATA_WIDTH(DW)) ifc ();

    int_ctrl #(.NUM_SRC(NS), .DATA_WIDTH(DW)) dut (
        .clk (clk),
        .rst (rst),
        .src (src),
        .bus (ifc)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model: one register per software-visible quantity, the
    // synchroniser seen as the last three samples of src.
    bit [NS-1:0] m_en, m_pend, m_esel;
    bit [NS-1:0] smp1, smp2, smp3;
    int          m_state, m_id;
    bit [DW-1:0] m_rdata;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_en = '0; m_pend = '0; m_esel = '0;
        smp1 = '0; smp2 = '0; smp3 = '0;
        m_state = ST_IDLE; m_id = 0; m_rdata = '0;
    endtask

    task automatic model_step();
        bit [NS-1:0] elig, n_pend, n_en, n_esel, n_s3;
        bit [DW-1:0] rv;
        int win, ns, nid;
        bit took;

        rv = '0;
        if (ifc.rd) begin
            case (ifc.addr)
                2'd0: rv = DW'(m_en);
                2'd1: rv = DW'(m_pend);
                2'd2: rv = DW'(m_esel);
                default: begin
                    rv = DW'(m_id);
                    rv[DW-1] = (m_state == ST_SVC);
                end
            endcase
        end

        elig = m_pend & m_en;
        win  = -1;
        for (int i = 0; i < NS; i++) if (elig[i] && win < 0) win = i;

        took = 0; ns = m_state; nid = m_id;
        if (m_state == ST_IDLE) begin
            if (win >= 0) begin ns = ST_REQ; nid = win; end
        end else if (m_state == ST_REQ) begin
            if (ifc.int_ack) begin ns = ST_SVC; took = 1; end
            else if (win < 0) ns = ST_IDLE;
            else nid = win;
        end else begin
            if (ifc.eoi) ns = ST_IDLE;
        end

        for (int i = 0; i < NS; i++) begin
            if (m_esel[i]) begin
                bit rise, clr;
                rise = smp2[i] && !smp3[i];
                clr  = (took && m_id == i) || (ifc.wr && ifc.addr == 2'd1 && ifc.wdata[i]);
                n_pend[i] = rise || (m_pend[i] && !clr);
            end else begin
                n_pend[i] = smp2[i];
            end
        end

        n_en   = (ifc.wr && ifc.addr == 2'd0) ? ifc.wdata[NS-1:0] : m_en;
        n_esel = (ifc.wr && ifc.addr == 2'd2) ? ifc.wdata[NS-1:0] : m_esel;
        n_s3   = smp2;
        for (int i = 0; i < NS; i++) if (n_esel[i] != m_esel[i]) n_s3[i] = smp1[i];

        m_rdata = rv; m_state = ns; m_id = nid; m_pend = n_pend;
        m_en = n_en; m_esel = n_esel;
        smp3 = n_s3; smp2 = smp1; smp1 = src;
    endtask

    // One clock: model follows the edge, outputs compared on the falling edge,
    // then single-cycle strobes are withdrawn.
    task automatic cycle();
        @(posedge clk);
        if (!rst) model_reset(); else model_step();
        @(negedge clk);
        check("hwint",  32'(ifc.hwint),  32'(m_state == ST_REQ));
        check("int_id", 32'(ifc.int_id), 32'(m_id));
        check("rdata",  ifc.rdata,       m_rdata);
        ifc.wr = 1'b0; ifc.rd = 1'b0; ifc.int_ack = 1'b0; ifc.eoi = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        cycle();
        cycle();
        check("rst_hwint", 32'(ifc.hwint), 32'd0);
        check("rst_rdata", ifc.rdata, 32'd0);
        rst = 1'b1;
    endtask

    task automatic reg_write(input logic [1:0] a, input logic [31:0] d);
        ifc.wr = 1'b1; ifc.addr = a; ifc.wdata = d;
        cycle();
    endtask

    task automatic reg_read(input string tag, input logic [1:0] a, input logic [31:0] exp);
        ifc.rd = 1'b1; ifc.addr = a;
        cycle();
        check(tag, ifc.rdata, exp);
    endtask

    initial begin
        ifc.addr = '0; ifc.wr = 1'b0; ifc.rd = 1'b0; ifc.wdata = '0;
        ifc.int_ack = 1'b0; ifc.eoi = 1'b0;
        model_reset();

        // Edge source 0: 4-cycle request latency, ack clears pending.
        do_reset();
        reg_write(2'd0, 32'h01);
        reg_write(2'd2, 32'h01);
        src = 8'h01; cycle();
        src = 8'h00; cycle(); cycle();
        check("edge_lat3", 32'(ifc.hwint), 32'd0);
        cycle();
        check("edge_lat4", 32'(ifc.hwint), 32'd1);
        check("edge_id", 32'(ifc.int_id), 32'd0);
        ifc.int_ack = 1'b1; cycle();
        check("ack_hwint", 32'(ifc.hwint), 32'd0);
        reg_read("ack_pend", 2'd1, 32'h0);
        reg_read("svc_active", 2'd3, 32'h8000_0000);
        ifc.eoi = 1'b1; cycle();
        cycle(); cycle();
        check("eoi_hwint", 32'(ifc.hwint), 32'd0);
        reg_read("idle_active", 2'd3, 32'h0);

        // Level sources 2 and 5: priority, then re-request while held.
        do_reset();
        reg_write(2'd0, 32'hFFFF_FFFF);
        reg_read("en_mask", 2'd0, 32'hFF);
        src = 8'h24;
        repeat (4) cycle();
        check("lvl_id", 32'(ifc.int_id), 32'd2);
        ifc.int_ack = 1'b1; cycle();
        ifc.eoi = 1'b1; cycle();
        cycle();
        check("lvl_rereq", 32'(ifc.int_id), 32'd2);
        check("lvl_rereq_hw", 32'(ifc.hwint), 32'd1);
        ifc.int_ack = 1'b1; src = 8'h20; cycle();
        ifc.eoi = 1'b1; repeat (5) cycle();
        check("lvl_next", 32'(ifc.int_id), 32'd5);

        // Random traffic with occasional asynchronous resets.
        for (int n = 0; n < 4000; n++) begin
            for (int b = 0; b < NS; b++) if ($urandom_range(0, 9) == 0) src[b] = ~src[b];
            if ($urandom_range(0, 11) == 0) begin
                ifc.wr = 1'b1; ifc.addr = 2'($urandom_range(0, 3)); ifc.wdata = $urandom;
            end
            if ($urandom_range(0, 2) == 0) begin
                ifc.rd = 1'b1;
                if (!ifc.wr) ifc.addr = 2'($urandom_range(0, 3));
            end
            ifc.int_ack = ($urandom_range(0, 4) == 0);
            ifc.eoi     = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 399) == 0) begin
                #2 rst = 1'b0;
                cycle();
                cycle();
                rst = 1'b1;
            end else begin
                cycle();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
